// File: rtl/aes_dec_iter.sv
// ---------------------------------------------------------------------------
// aes_dec_iter -- iterative AES-128 inverse cipher, one inverse round per clock.
//
// A ciphertext block is taken over an in_valid/in_ready handshake, whitened
// with the last round key, then walked down the pre-expanded key schedule one
// round per cycle. The recovered plaintext is offered over an
// out_valid/out_ready handshake and held until the consumer takes it.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   in_valid     in   cipher_text is valid
//   in_ready     out  engine can accept a block (IDLE and not in reset)
//   cipher_text  in   [0:127] ciphertext, byte 0 = bits [0:7], column-major
//   keys         in   [0:128*(Nr+1)-1] schedule, round key i at bits 128*i +: 128
//   out_valid    out  plain_text is valid
//   out_ready    in   consumer takes plain_text
//   plain_text   out  [0:127] recovered plaintext, same byte order
//   busy         out  high while rounds are executing
//
// Also contains the helper modules aes_inv_sbox and aes_inv_mix_col.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// aes_inv_sbox -- AES inverse substitution box (table lookup).
//   a_i  in   input byte
//   b_o  out  InvSubBytes(a_i)
// ---------------------------------------------------------------------------
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] b_o
);
    // Entry for byte value v sits at bits [8*v : 8*v+7]; rows hold 16 entries.
    localparam logic [0:2047] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign b_o = INV_SBOX_TABLE[{a_i, 3'b000} +: 8];
endmodule

// ---------------------------------------------------------------------------
// aes_inv_mix_col -- InvMixColumns on one 32-bit column.
//   col_i  in   column bytes a0..a3 (a0 at bits [0:7])
//   col_o  out  transformed column, same byte order
// ---------------------------------------------------------------------------
module aes_inv_mix_col (
    input  logic [0:31] col_i,
    output logic [0:31] col_o
);
    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    logic [3:0][7:0] m09;
    logic [3:0][7:0] m0b;
    logic [3:0][7:0] m0d;
    logic [3:0][7:0] m0e;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mul
            logic [7:0] a;
            logic [7:0] x2;
            logic [7:0] x4;
            logic [7:0] x8;
            assign a       = col_i[8*gi +: 8];
            assign x2      = xtime(a);
            assign x4      = xtime(x2);
            assign x8      = xtime(x4);
            assign m09[gi] = x8 ^ a;
            assign m0b[gi] = x8 ^ x2 ^ a;
            assign m0d[gi] = x8 ^ x4 ^ a;
            assign m0e[gi] = x8 ^ x4 ^ x2;
        end

        // Row r of the inverse matrix is {0e,0b,0d,09} rotated right by r.
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign col_o[8*gi +: 8] = m0e[gi] ^ m0b[(gi + 1) % 4]
                                    ^ m0d[(gi + 2) % 4] ^ m09[(gi + 3) % 4];
        end
    endgenerate
endmodule

// ---------------------------------------------------------------------------
// aes_dec_iter -- top level (see file header for port summary).
// ---------------------------------------------------------------------------
module aes_dec_iter #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:127]             cipher_text,
    input  logic [0:128*(Nr+1)-1]    keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:127]             plain_text,
    output logic                     busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] FIRST_ROUND = 4'(Nr - 1);

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] state_q, state_d;
    logic [0:127] plain_q, plain_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [0:127] rk [0:Nr];
    logic [0:127] rk_sel;
    logic [0:127] shifted;
    logic [0:127] subbed;
    logic [0:127] keyed;
    logic [0:127] mixed;

    genvar gi;
    generate
        for (gi = 0; gi <= Nr; gi++) begin : g_rk
            assign rk[gi] = keys[128*gi +: 128];
        end

        // InvShiftRows: row r rotates right by r columns, so output column c
        // of row r comes from input column (c - r) mod 4. Pure wiring.
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;

            assign shifted[8*gi +: 8] = state_q[8*SRC +: 8];

            aes_inv_sbox u_inv_sbox (
                .a_i (shifted[8*gi +: 8]),
                .b_o (subbed[8*gi +: 8])
            );
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            aes_inv_mix_col u_inv_mix_col (
                .col_i (keyed[32*gi +: 32]),
                .col_o (mixed[32*gi +: 32])
            );
        end
    endgenerate

    // round_q only ever holds 0..Nr-1 while the datapath result is used.
    assign rk_sel = rk[round_q];

    // AddRoundKey precedes InvMixColumns; the final round takes keyed directly.
    assign keyed = subbed ^ rk_sel;

    assign in_ready = (fsm_q == IDLE) && !reset;

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        state_d     = state_q;
        plain_d     = plain_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = cipher_text ^ rk[Nr];
                    round_d = FIRST_ROUND;
                    busy_d  = 1'b1;
                    fsm_d   = ROUND;
                end
            end

            ROUND: begin
                if (round_q != 4'd0) begin
                    state_d = mixed;
                    round_d = round_q - 4'd1;
                end else begin
                    plain_d     = keyed;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    fsm_d       = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end

            default: begin
                fsm_d       = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            plain_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_q     <= state_d;
            plain_q     <= plain_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign plain_text = plain_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_aes_dec_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_iter -- self-checking bench for aes_dec_iter.
// Reference: byte-level AES model (GF multiply, S-box derived from field
// inverse + affine map, key expansion, forward and inverse cipher).
// ---------------------------------------------------------------------------
module tb_aes_dec_iter;
    localparam int NR = 10;
    localparam int NV = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [0:127]       cipher_text;
    logic [0:128*11-1]  keys;
    logic               out_valid;
    logic               out_ready;
    logic [0:127]       plain_text;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [0:127] last_pt;

    always #5 clk = ~clk;

    aes_dec_iter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cipher_text (cipher_text),
        .keys        (keys),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plain_text  (plain_text),
        .busy        (busy)
    );

    // ------------------------------------------------------------ model
    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic logic [0:1407] key_expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] ks;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                  ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? isbox_t[s[8*k +: 8]] : sbox_t[s[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [0:127] shift_rows(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[8*(4*c+rw) +: 8] = s[8*(4*((inv ? c - rw + 4 : c + rw) % 4) + rw) +: 8];
        return r;
    endfunction

    function automatic logic [0:127] mix_cols(input logic [0:127] s, input bit inv);
        logic [0:127] r;
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        cf[0] = inv ? 8'h0e : 8'h02;
        cf[1] = inv ? 8'h0b : 8'h03;
        cf[2] = inv ? 8'h0d : 8'h01;
        cf[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(cf[(j - rw + 4) % 4], s[8*(4*c+j) +: 8]);
                r[8*(4*c+rw) +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:1407] ks, input logic [0:127] pt);
        logic [0:127] s;
        s = pt ^ ks[0 +: 128];
        for (int r = 1; r <= NR; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r < NR) s = mix_cols(s, 1'b0);
            s = s ^ ks[128*r +: 128];
        end
        return s;
    endfunction

    function automatic logic [0:127] decrypt(input logic [0:1407] ks, input logic [0:127] ct);
        logic [0:127] s;
        s = ct ^ ks[128*NR +: 128];
        for (int r = NR - 1; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[128*r +: 128];
            if (r > 0) s = mix_cols(s, 1'b1);
        end
        return s;
    endfunction

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [0:127]  key;
        logic [0:1407] ks;
        logic [0:127]  ct;
        logic [0:127]  pt;
    } vec_t;

    vec_t tab [NV];

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Streams tab[first .. first+n-1] through the DUT with in_valid held high
    // until the last block is accepted; after each accept cipher_text moves to
    // the next block, so a busy engine sees a different block on its input.
    // out_ready is held low for bp cycles after each out_valid.
    task automatic run_stream(input int first, input int n, input int bp);
        int  acc_cyc [16];
        int  acc_i;
        int  out_i;
        int  hold_cnt;
        bit  seen;
        bit  in_flight;
        bit  pend;
        int  limit;
        acc_i = 0; out_i = 0; hold_cnt = 0;
        seen = 1'b0; in_flight = 1'b0; pend = 1'b0;
        limit = (NR + 4 + bp) * n + 20;
        keys        = tab[first].ks;
        cipher_text = tab[first].ct;
        in_valid    = 1'b1;
        out_ready   = (bp == 0);
        for (int cyc = 0; cyc < limit && out_i < n; cyc++) begin
            chk("in_ready", 128'(in_ready), 128'(!in_flight));
            if (in_flight) begin
                chk("busy", 128'(busy), 128'(!out_valid));
            end else begin
                chk("idle_out_valid", 128'(out_valid), 128'(0));
                chk("idle_busy", 128'(busy), 128'(0));
                chk("pt_retained", plain_text, last_pt);
            end
            if (out_valid && in_flight) begin
                if (!seen) begin
                    seen     = 1'b1;
                    hold_cnt = 0;
                    chk("latency", 128'(cyc - acc_cyc[out_i] - 1), 128'(NR));
                    chk("plain_text", plain_text, tab[first+out_i].pt);
                    $display("[TB] block %0d: ct=%h pt=%h", first + out_i,
                             tab[first+out_i].ct, plain_text);
                    if (out_i + 1 < n) keys = tab[first+out_i+1].ks;
                end else begin
                    chk("hold_pt", plain_text, tab[first+out_i].pt);
                end
                out_ready = (hold_cnt >= bp);
                hold_cnt++;
                if (out_ready) begin
                    last_pt   = tab[first+out_i].pt;
                    out_i++;
                    seen      = 1'b0;
                    in_flight = 1'b0;
                end
            end
            pend = in_valid && in_ready;
            if (pend) begin
                acc_cyc[acc_i] = cyc;
                if (acc_i > 0 && bp == 0)
                    chk("accept_spacing", 128'(cyc - acc_cyc[acc_i-1]), 128'(NR + 2));
                in_flight = 1'b1;
            end
            @(negedge clk);
            if (pend) begin
                acc_i++;
                if (acc_i < n) cipher_text = tab[first+acc_i].ct;
                else           in_valid    = 1'b0;
            end
        end
        chk("blocks_done", 128'(out_i), 128'(n));
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ main
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cipher_text = '0; keys = '0; last_pt = '0;

        build_tables();
        tab[0].key = 128'h000102030405060708090a0b0c0d0e0f;
        tab[0].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tab[0].pt  = 128'h00112233445566778899aabbccddeeff;
        tab[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tab[1].ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        tab[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
        for (int i = 0; i < 2; i++) tab[i].ks = key_expand(tab[i].key);
        for (int i = 2; i < NV; i++) begin
            tab[i].key = rnd128();
            tab[i].ks  = key_expand(tab[i].key);
            if (i < 5) begin
                tab[i].ct = rnd128();
                tab[i].pt = decrypt(tab[i].ks, tab[i].ct);
            end else begin
                tab[i].pt = rnd128();
                tab[i].ct = encrypt(tab[i].ks, tab[i].pt);
            end
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("in_ready_in_reset", 128'(in_ready), 128'(0));
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_plain", plain_text, 128'(0));

        // Table vectors one at a time
        for (int i = 0; i < NV; i++) run_stream(i, 1, 0);

        // Back-pressure: 5 cycles of out_ready low after out_valid
        run_stream(0, 1, 5);

        // Back-to-back with in_valid held high: C.1 then B, then the randoms
        run_stream(0, 2, 0);
        run_stream(2, NV - 2, 0);
        run_stream(3, 3, 2);

        // Reset at the 5th ROUND cycle
        keys = tab[0].ks; cipher_text = tab[0].ct; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy", 128'(busy), 128'(1));
        repeat (4) @(negedge clk);
        chk("mid_busy_r5", 128'(busy), 128'(1));
        reset = 1'b1; in_valid = 1'b1; cipher_text = tab[1].ct;
        #1;
        chk("mid_in_ready_rst", 128'(in_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_in_ready", 128'(in_ready), 128'(1));
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_plain", plain_text, 128'(0));
        chk("mid_busy_clr", 128'(busy), 128'(0));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("aborted_no_valid", 128'(out_valid), 128'(0));
            chk("aborted_no_busy", 128'(busy), 128'(0));
        end
        last_pt = '0;
        run_stream(0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
